// File: rtl/qupls_areg_read_sched_if.sv
// Bus bundle for qupls_areg_read_sched: decode-side request group,
// register-file read ports and the completed operand set.
interface qupls_areg_read_sched_if #(
  parameter int NREQ   = 12,
  parameter int NPORTS = 4,
  parameter int WID    = 64
);
  logic                             grp_valid;
  logic                             grp_ready;
  logic [NREQ-1:0]                  req_v;
  logic [NREQ-1:0][8:0]             req_reg;
  logic [NPORTS-1:0]                port_busy;
  logic [NPORTS-1:0]                rf_rv;
  logic [NPORTS-1:0][8:0]           rf_ra;
  logic [NPORTS-1:0][WID-1:0]       rf_rd;
  logic                             out_valid;
  logic                             out_ready;
  logic [NREQ-1:0][WID-1:0]         opnd;

  // Scheduler side
  modport slave (
    input  grp_valid, req_v, req_reg, port_busy, rf_rd, out_ready,
    output grp_ready, rf_rv, rf_ra, out_valid, opnd
  );

  // Decode / register-file / consumer side
  modport master (
    output grp_valid, req_v, req_reg, port_busy, rf_rd, out_ready,
    input  grp_ready, rf_rv, rf_ra, out_valid, opnd
  );
endinterface

// File: rtl/qupls_areg_read_sched.sv
// qupls_areg_read_sched: sequences the architectural-register source
// operands of one decoded instruction group onto NPORTS register-file read
// ports and collects the returned values into an index-aligned operand set.
// Optional feature: define QUPLS_RDARB_DEDUP_EN to let requests for the same
// register within one issue cycle share a single read port.
module qupls_areg_read_sched #(
  parameter int NREQ   = 12,
  parameter int NPORTS = 4,
  parameter int WID    = 64
) (
  input  logic                    clk,
  input  logic                    rst,
  qupls_areg_read_sched_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

  state_t                       state_q, state_d;
  logic [NREQ-1:0]              pend_q;
  logic [NREQ-1:0][8:0]         regs_q;
  logic [NREQ-1:0]              init_pend;
  logic [NREQ-1:0][WID-1:0]     opnd_q;

  // Issue stage (p0): combinational port allocation from registered state
  logic [NPORTS-1:0]            rv_p0;
  logic [NPORTS-1:0][8:0]       ra_p0;
  logic [NPORTS-1:0][NREQ-1:0]  grant_p0;
  logic [NREQ-1:0]              served_p0;
  logic [NPORTS-1:0]            taken;

  // Return stage (p1): which requests each port's read data belongs to
  logic [NPORTS-1:0][NREQ-1:0]  grant_p1;

  // A request needs a port only if valid and not the hardwired-zero r0
  always_comb begin
    init_pend = '0;
    for (int i = 0; i < NREQ; i++)
      init_pend[i] = bus.req_v[i] && (bus.req_reg[i] != 9'd0);
  end

  // Walk pending requests in index order, giving each the lowest free port
  always_comb begin
    rv_p0     = '0;
    ra_p0     = '0;
    grant_p0  = '0;
    served_p0 = '0;
    taken     = bus.port_busy;
    if (state_q == ISSUE) begin
      for (int i = 0; i < NREQ; i++) begin
        if (pend_q[i]) begin
`ifdef QUPLS_RDARB_DEDUP_EN
          for (int p = 0; p < NPORTS; p++) begin
            if (!served_p0[i] && rv_p0[p] && (ra_p0[p] == regs_q[i])) begin
              grant_p0[p][i] = 1'b1;
              served_p0[i]   = 1'b1;
            end
          end
`endif
          for (int p = 0; p < NPORTS; p++) begin
            if (!served_p0[i] && !taken[p]) begin
              taken[p]       = 1'b1;
              rv_p0[p]       = 1'b1;
              ra_p0[p]       = regs_q[i];
              grant_p0[p][i] = 1'b1;
              served_p0[i]   = 1'b1;
            end
          end
        end
      end
    end
  end

  // Next-state decode
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.grp_valid) state_d = (init_pend == '0) ? DONE : ISSUE;
      ISSUE:   if ((pend_q & ~served_p0) == '0) state_d = DRAIN;
      DRAIN:   state_d = DONE;
      DONE:    if (bus.out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Control state: FSM, pending mask and return-pipeline grants
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      pend_q   <= '0;
      grant_p1 <= '0;
    end else begin
      state_q  <= state_d;
      grant_p1 <= grant_p0;
      if (state_q == IDLE && bus.grp_valid)
        pend_q <= init_pend;
      else if (state_q == ISSUE)
        pend_q <= pend_q & ~served_p0;
    end
  end

  // Register numbers captured at group accept
  always_ff @(posedge clk) begin
    if (state_q == IDLE && bus.grp_valid)
      regs_q <= bus.req_reg;
  end

  // Operand capture: cleared on accept, filled one cycle after each issue
  always_ff @(posedge clk) begin
    if (rst) begin
      opnd_q <= '0;
    end else begin
      if (state_q == IDLE && bus.grp_valid)
        opnd_q <= '0;
      for (int p = 0; p < NPORTS; p++)
        for (int i = 0; i < NREQ; i++)
          if (grant_p1[p][i])
            opnd_q[i] <= bus.rf_rd[p];
    end
  end

  assign bus.grp_ready = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.rf_rv     = rv_p0;
  assign bus.rf_ra     = ra_p0;
  assign bus.opnd      = opnd_q;

endmodule

// File: tb/tb_qupls_areg_read_sched.sv
// Testbench for qupls_areg_read_sched: table of request groups with
// hand-computed completion cycle, port usage and operand values, plus
// directed sequences for dedup, busy ports, DONE hold and mid-group reset.
module tb_qupls_areg_read_sched;
  localparam int NREQ   = 12;
  localparam int NPORTS = 4;
  localparam int WID    = 64;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  qupls_areg_read_sched_if #(.NREQ(NREQ), .NPORTS(NPORTS), .WID(WID)) bus ();

  qupls_areg_read_sched #(.NREQ(NREQ), .NPORTS(NPORTS), .WID(WID)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [NREQ-1:0]      v;
    logic [NREQ-1:0][8:0] regs;
    logic [NPORTS-1:0]    busy;
    int                   busy_last;
    int                   exp_done;
    int                   exp_ports;
    int                   exp_icyc;
    int                   hold;
  } vec_t;

  vec_t vecs [7];

  int checks = 0;
  int errors = 0;

  logic [NPORTS-1:0]      busy_val;
  int                     busy_last;
  logic [NPORTS-1:0]      rv_s;
  logic [NPORTS-1:0][8:0] ra_s;
  logic [NPORTS-1:0]      lrv [0:63];
  logic [NPORTS-1:0][8:0] lra [0:63];

  function automatic logic [WID-1:0] rdata(input logic [8:0] r);
    return 64'hC0DE_0000_0000_0000 | {55'd0, r};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Register file model: data for the register read last cycle, junk elsewhere
  always @(negedge clk) begin
    rv_s = bus.rf_rv;
    ra_s = bus.rf_ra;
  end
  always @(posedge clk) begin
    #1;
    for (int p = 0; p < NPORTS; p++)
      bus.rf_rd[p] = rv_s[p] ? rdata(ra_s[p]) : (64'hBAD0_0000_0000_0000 | 64'(p));
  end

  // A busy port must never be driven
  always @(negedge clk) begin
    if (rst !== 1'b1 && bus.rf_rv !== '0) begin
      checks++;
      if ((bus.rf_rv & bus.port_busy) !== '0) begin
        errors++;
        $display("FAIL busy_port_driven: rf_rv %b port_busy %b", bus.rf_rv, bus.port_busy);
      end
    end
  end

  task automatic start_group(input logic [NREQ-1:0] v, input logic [NREQ-1:0][8:0] regs);
    for (int c = 0; c < 64; c++) begin
      lrv[c] = '0;
      lra[c] = '0;
    end
    @(posedge clk); #1;
    bus.grp_valid = 1'b1;
    bus.req_v     = v;
    bus.req_reg   = regs;
    bus.port_busy = '0;
    @(negedge clk);
    check("grp_ready_at_accept", 64'(bus.grp_ready), 64'd1);
    @(posedge clk); #1;
    bus.grp_valid = 1'b0;
    bus.req_v     = '0;
    bus.port_busy = (busy_last >= 1) ? busy_val : '0;
  endtask

  task automatic run_to_done(output int done_cyc);
    bit found;
    found    = 1'b0;
    done_cyc = -1;
    for (int c = 1; c <= 40 && !found; c++) begin
      @(negedge clk);
      lrv[c] = bus.rf_rv;
      lra[c] = bus.rf_ra;
      if (bus.out_valid === 1'b1) begin
        found    = 1'b1;
        done_cyc = c;
      end else begin
        @(posedge clk); #1;
        bus.port_busy = (c + 1 <= busy_last) ? busy_val : '0;
      end
    end
  endtask

  task automatic finish_group(input int hold);
    logic [NREQ-1:0][WID-1:0] snap;
    snap = bus.opnd;
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      bus.grp_valid = 1'b1;
      bus.out_ready = 1'b0;
      @(negedge clk);
      check("hold_out_valid", 64'(bus.out_valid), 64'd1);
      check("hold_grp_ready", 64'(bus.grp_ready), 64'd0);
      checks++;
      if (bus.opnd !== snap) begin
        errors++;
        $display("FAIL hold_opnd_stable: opnd[0] %h expected %h", bus.opnd[0], snap[0]);
      end
    end
    @(posedge clk); #1;
    bus.grp_valid = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    @(negedge clk);
    check("post_handshake_grp_ready", 64'(bus.grp_ready), 64'd1);
    check("post_handshake_out_valid", 64'(bus.out_valid), 64'd0);
  endtask

  task automatic run_vec(input int t);
    int d, ports, icyc;
    logic [WID-1:0] exp;
    busy_val  = vecs[t].busy;
    busy_last = vecs[t].busy_last;
    start_group(vecs[t].v, vecs[t].regs);
    run_to_done(d);
    check($sformatf("v%0d_done_cycle", t), 64'(d), 64'(vecs[t].exp_done));
    ports = 0;
    icyc  = 0;
    for (int c = 1; c <= 40; c++) begin
      ports += $countones(lrv[c]);
      if (lrv[c] != '0) icyc++;
    end
    check($sformatf("v%0d_port_issues", t), 64'(ports), 64'(vecs[t].exp_ports));
    check($sformatf("v%0d_issue_cycles", t), 64'(icyc), 64'(vecs[t].exp_icyc));
    for (int i = 0; i < NREQ; i++) begin
      exp = (vecs[t].v[i] && vecs[t].regs[i] != 9'd0) ? rdata(vecs[t].regs[i]) : '0;
      check($sformatf("v%0d_opnd%0d", t, i), bus.opnd[i], exp);
    end
    finish_group(vecs[t].hold);
    busy_last = 0;
  endtask

  initial begin
    for (int t = 0; t < 7; t++) begin
      vecs[t].v = '0; vecs[t].regs = '0; vecs[t].busy = '0; vecs[t].busy_last = 0;
      vecs[t].exp_done = 0; vecs[t].exp_ports = 0; vecs[t].exp_icyc = 0; vecs[t].hold = 0;
    end
    // 0: twelve distinct registers 1..12
    vecs[0].v = 12'hFFF;
    for (int i = 0; i < NREQ; i++) vecs[0].regs[i] = 9'(i + 1);
    vecs[0].exp_done = 5; vecs[0].exp_ports = 12; vecs[0].exp_icyc = 3;
    // 1: only r0 requests valid, nonzero registers invalid
    vecs[1].v = 12'h555;
    for (int i = 0; i < NREQ; i++) vecs[1].regs[i] = (i % 2 == 1) ? 9'(40 + i) : 9'd0;
    vecs[1].exp_done = 1; vecs[1].exp_ports = 0; vecs[1].exp_icyc = 0; vecs[1].hold = 2;
    // 2: {5,5,5,5,7}, held five cycles in DONE
    vecs[2].v = 12'h01F;
    for (int i = 0; i < 4; i++) vecs[2].regs[i] = 9'd5;
    vecs[2].regs[4] = 9'd7;
`ifdef QUPLS_RDARB_DEDUP_EN
    vecs[2].exp_done = 3; vecs[2].exp_ports = 2; vecs[2].exp_icyc = 1;
`else
    vecs[2].exp_done = 4; vecs[2].exp_ports = 5; vecs[2].exp_icyc = 2;
`endif
    vecs[2].hold = 5;
    // 3: all ports busy cycles 1-3
    vecs[3].v = 12'h00F;
    for (int i = 0; i < 4; i++) vecs[3].regs[i] = 9'(20 + i);
    vecs[3].busy = 4'hF; vecs[3].busy_last = 3;
    vecs[3].exp_done = 6; vecs[3].exp_ports = 4; vecs[3].exp_icyc = 1; vecs[3].hold = 1;
    // 4: ports 0 and 2 busy cycles 1-2
    vecs[4].v = 12'h007;
    vecs[4].regs[0] = 9'd30; vecs[4].regs[1] = 9'd31; vecs[4].regs[2] = 9'd32;
    vecs[4].busy = 4'b0101; vecs[4].busy_last = 2;
    vecs[4].exp_done = 4; vecs[4].exp_ports = 3; vecs[4].exp_icyc = 2;
    // 5: sparse mix of valid, invalid and r0
    vecs[5].v = 12'b1010_0000_0101;
    vecs[5].regs[0] = 9'd63; vecs[5].regs[1] = 9'd44; vecs[5].regs[2] = 9'd0;
    vecs[5].regs[9] = 9'd100; vecs[5].regs[11] = 9'd511;
    vecs[5].exp_done = 3; vecs[5].exp_ports = 3; vecs[5].exp_icyc = 1;
    // 6: {9,9,10,11,12,13,9}
    vecs[6].v = 12'h07F;
    vecs[6].regs[0] = 9'd9;  vecs[6].regs[1] = 9'd9;  vecs[6].regs[2] = 9'd10;
    vecs[6].regs[3] = 9'd11; vecs[6].regs[4] = 9'd12; vecs[6].regs[5] = 9'd13;
    vecs[6].regs[6] = 9'd9;
`ifdef QUPLS_RDARB_DEDUP_EN
    vecs[6].exp_ports = 5;
`else
    vecs[6].exp_ports = 7;
`endif
    vecs[6].exp_done = 4; vecs[6].exp_icyc = 2;

    bus.grp_valid = 1'b0; bus.req_v = '0; bus.req_reg = '0;
    bus.port_busy = '0;   bus.out_ready = 1'b0;
    busy_val = '0; busy_last = 0;
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("reset_grp_ready", 64'(bus.grp_ready), 64'd1);
    check("reset_out_valid", 64'(bus.out_valid), 64'd0);
    check("reset_rf_rv", 64'(bus.rf_rv), 64'd0);
    check("reset_rf_ra", 64'(bus.rf_ra), 64'd0);
    checks++;
    if (bus.opnd !== '0) begin
      errors++;
      $display("FAIL reset_opnd: opnd[0] %h expected 0", bus.opnd[0]);
    end
    @(posedge clk); #1;
    rst = 1'b0;

    for (int t = 0; t < 7; t++) begin
      run_vec(t);
      if (t == 0) begin
        check("v0_cyc1_ra", 64'(lra[1]), 64'({9'd4, 9'd3, 9'd2, 9'd1}));
        check("v0_cyc2_ra", 64'(lra[2]), 64'({9'd8, 9'd7, 9'd6, 9'd5}));
        check("v0_cyc3_ra", 64'(lra[3]), 64'({9'd12, 9'd11, 9'd10, 9'd9}));
      end
      if (t == 2) begin
`ifdef QUPLS_RDARB_DEDUP_EN
        check("v2_cyc1_rv", 64'(lrv[1]), 64'(4'b0011));
        check("v2_cyc1_ra", 64'(lra[1]), 64'({9'd0, 9'd0, 9'd7, 9'd5}));
`else
        check("v2_cyc1_rv", 64'(lrv[1]), 64'(4'b1111));
        check("v2_cyc1_ra", 64'(lra[1]), 64'({9'd5, 9'd5, 9'd5, 9'd5}));
        check("v2_cyc2_rv", 64'(lrv[2]), 64'(4'b0001));
        check("v2_cyc2_ra0", 64'(lra[2][0]), 64'd7);
`endif
      end
      if (t == 3) begin
        check("v3_busy_no_rv", 64'(lrv[1] | lrv[2] | lrv[3]), 64'd0);
        check("v3_cyc4_rv", 64'(lrv[4]), 64'(4'hF));
      end
      if (t == 4) begin
        check("v4_cyc1_rv", 64'(lrv[1]), 64'(4'b1010));
        check("v4_cyc1_ra", 64'(lra[1]), 64'({9'd31, 9'd0, 9'd30, 9'd0}));
        check("v4_cyc2_rv", 64'(lrv[2]), 64'(4'b0010));
        check("v4_cyc2_ra1", 64'(lra[2][1]), 64'd32);
      end
    end

    // Reset during the second issue cycle of a twelve-request group
    busy_val = '0; busy_last = 0;
    start_group(vecs[0].v, vecs[0].regs);
    @(negedge clk);
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    check("rst_cyc2_rf_rv", 64'(bus.rf_rv), 64'(4'hF));
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("after_rst_grp_ready", 64'(bus.grp_ready), 64'd1);
    check("after_rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("after_rst_rf_rv", 64'(bus.rf_rv), 64'd0);
    checks++;
    if (bus.opnd !== '0) begin
      errors++;
      $display("FAIL after_rst_opnd: opnd[0] %h expected 0", bus.opnd[0]);
    end
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("aborted_no_out_valid", 64'(bus.out_valid), 64'd0);
    end
    run_vec(5);
    run_vec(0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Hard bound in case the flow stalls somewhere unexpected
  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
